dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 32 +++
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_access_check.sv | 33 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter slice:
//   - rw_mode encodings understood by the data memory
//   - arbiter FSM state type
//   - access_bytes(): rw_mode -> number of bytes touched by the access
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'b00,
        MODE_HALF = 2'b01,
        MODE_WORD = 2'b10,
        MODE_BAD  = 2'b11
    } rw_mode_e;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } arb_state_e;

    // The invalid mode reports one byte so that range arithmetic stays sane;
    // the invalid mode itself is flagged separately by the checker.
    function automatic logic [2:0] access_bytes(input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            MODE_HALF: n = 3'd2;
            MODE_WORD: n = 3'd4;
            default:   n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles both requester ports and the data-memory port of the arbiter.
//   Requester side : req*/we*/mode*/addr*/wdata*/lock1 in, gnt*/rvalid*/rdata*/err* out
//   Memory side    : mem_wr_en/mem_rw_mode/mem_addr/mem_w_data out, mem_r_data in
//   slave  modport : the arbiter
//   master modport : the requesters and the memory (environment)
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  req0,    req1;
    logic                  we0,     we1;
    logic [1:0]            mode0,   mode1;
    logic [ADDR_WIDTH-1:0] addr0,   addr1;
    logic [DATA_WIDTH-1:0] wdata0,  wdata1;
    logic                  lock1;
    logic                  gnt0,    gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0,  rdata1;
    logic                  err0,    err1;
    logic                  mem_wr_en;
    logic [1:0]            mem_rw_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [DATA_WIDTH-1:0] mem_r_data;

    modport slave (
        input  req0, req1, we0, we1, mode0, mode1, addr0, addr1,
               wdata0, wdata1, lock1, mem_r_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_wr_en, mem_rw_mode, mem_addr, mem_w_data
    );

    modport master (
        output req0, req1, we0, we1, mode0, mode1, addr0, addr1,
               wdata0, wdata1, lock1, mem_r_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_wr_en, mem_rw_mode, mem_addr, mem_w_data
    );

endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check
//   Combinational legality check of one memory access.
//   mode_i : rw_mode of the access
//   addr_i : byte address of the access
//   bad_o  : 1 when the mode is invalid, the access is misaligned, or the
//            access would run past the top of the address space
module dmem_access_check
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  bad_o
);
    localparam int AW1 = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] last_byte;
    logic                misaligned;

    always_comb begin
        // One extra bit catches a last byte beyond 2^ADDR_WIDTH-1.
        last_byte = {1'b0, addr_i} + AW1'(access_bytes(mode_i)) - AW1'(1);
        case (mode_i)
            MODE_BYTE: misaligned = 1'b0;
            MODE_HALF: misaligned = addr_i[0];
            MODE_WORD: misaligned = |addr_i[1:0];
            default:   misaligned = 1'b1;
        endcase
        bad_o = misaligned | last_byte[ADDR_WIDTH];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the CPU (port 0) and a
//   loader/debug master (port 1). Round-robin on ties, bounded lock for
//   port 1, access checking, one registered response per grant.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes and the memory port (dmem_arbiter_if.slave)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LOCK_MAX   = 16
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_e            state_q, state_d;
    logic                  ptr_q, ptr_d;      // port granted last
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  gnt0, gnt1, any_gnt, lock_hold;
    logic                  win_we, win_bad;
    logic [1:0]            win_mode;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  resp_err_d;
    logic [DATA_WIDTH-1:0] resp_data_d;
    logic                  rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    // Arbitration / lock FSM. When a lock may not continue (lock1 or req1
    // dropped, or the run hit LOCK_MAX) that same cycle is arbitrated as if
    // OPEN, so port 0 gets the memory without a bubble.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lock_hold = (state_q == ST_LOCKED) && bus.req1 && bus.lock1 &&
                    (cnt_q < CNT_MAX);
        if (rst_n) begin
            if (lock_hold) begin
                gnt1  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                if (bus.req0 && bus.req1) begin
                    gnt0 = ptr_q;
                    gnt1 = ~ptr_q;
                end else begin
                    gnt0 = bus.req0;
                    gnt1 = bus.req1;
                end
                if (gnt1 && bus.lock1) begin
                    state_d = ST_LOCKED;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_OPEN;
                    cnt_d   = '0;
                end
            end
            if (gnt0) begin
                ptr_d = 1'b0;
            end else if (gnt1) begin
                ptr_d = 1'b1;
            end
        end
    end

    // Winner mux and memory drive; address/mode hold when idle.
    always_comb begin
        any_gnt     = gnt0 | gnt1;
        win_we      = gnt1 ? bus.we1    : bus.we0;
        win_mode    = gnt1 ? bus.mode1  : bus.mode0;
        win_addr    = gnt1 ? bus.addr1  : bus.addr0;
        win_wdata   = gnt1 ? bus.wdata1 : bus.wdata0;
        resp_err_d  = any_gnt & win_bad;
        resp_data_d = (any_gnt & ~win_we & ~win_bad) ? bus.mem_r_data : '0;
    end

    dmem_access_check #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_check (
        .mode_i (win_mode),
        .addr_i (win_addr),
        .bad_o  (win_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OPEN;
            ptr_q     <= 1'b1;
            cnt_q     <= '0;
            mode_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            if (any_gnt) begin
                mode_q  <= win_mode;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            err0_q    <= gnt0 & resp_err_d;
            err1_q    <= gnt1 & resp_err_d;
            rdata0_q  <= gnt0 ? resp_data_d : '0;
            rdata1_q  <= gnt1 ? resp_data_d : '0;
        end
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.err0        = err0_q;
    assign bus.err1        = err1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.mem_wr_en   = any_gnt & win_we & ~win_bad & rst_n;
    assign bus.mem_rw_mode = any_gnt ? win_mode  : mode_q;
    assign bus.mem_addr    = any_gnt ? win_addr  : addr_q;
    assign bus.mem_w_data  = any_gnt ? win_wdata : wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Drives both arbiter ports from per-port transaction queues, models the
//   byte-addressed data memory, and compares grants, memory drive and
//   responses against a rule-level reference model.
module tb_dmem_arbiter;
    localparam int DW        = 32;
    localparam int AW        = 12;
    localparam int LM        = 16;
    localparam int MEM_BYTES = 1 << AW;

    typedef struct {
        logic          we;
        logic [1:0]    mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LOCK_MAX  (LM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- environment data memory ----------------
    logic [7:0]    mem [MEM_BYTES];
    logic          mem_clr = 1'b0;
    logic          pre_en  = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_word = '0;
    logic [AW-1:0] ra1, ra2, ra3;

    assign ra1 = bus.mem_addr + 12'd1;
    assign ra2 = bus.mem_addr + 12'd2;
    assign ra3 = bus.mem_addr + 12'd3;
    assign bus.mem_r_data =
        (bus.mem_rw_mode == 2'b10) ? {mem[ra3], mem[ra2], mem[ra1], mem[bus.mem_addr]} :
        (bus.mem_rw_mode == 2'b01) ? {16'h0, mem[ra1], mem[bus.mem_addr]} :
                                     {24'h0, mem[bus.mem_addr]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (pre_en) begin
            mem[pre_addr]         <= pre_word[7:0];
            mem[pre_addr + 12'd1] <= pre_word[15:8];
            mem[pre_addr + 12'd2] <= pre_word[23:16];
            mem[pre_addr + 12'd3] <= pre_word[31:24];
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_w_data[7:0];
            if (bus.mem_rw_mode != 2'b00) mem[ra1] <= bus.mem_w_data[15:8];
            if (bus.mem_rw_mode == 2'b10) begin
                mem[ra2] <= bus.mem_w_data[23:16];
                mem[ra3] <= bus.mem_w_data[31:24];
            end
        end
    end

    // ---------------- reference model state ----------------
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [7:0]    ref_mem [MEM_BYTES];
    txn_t          q0[$];
    txn_t          q1[$];
    int            hist[$];
    int            m_last;          // port granted last
    int            m_run;           // consecutive locked port-1 grants
    logic [AW-1:0] m_addr_hold;
    logic [1:0]    m_mode_hold;
    bit            exp_rv  [2];
    bit            exp_err [2];
    logic [DW-1:0] exp_rd  [2];
    int            n_rv    [2];
    logic [DW-1:0] last_rd [2];
    logic          last_err[2];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] mode);
        return (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [1:0] mode, input logic [AW-1:0] addr);
        int a = int'(addr);
        if (mode == 2'd3)                 return 1'b1;
        if (mode == 2'd1 && a % 2 != 0)   return 1'b1;
        if (mode == 2'd2 && a % 4 != 0)   return 1'b1;
        return (a + nbytes(mode) > MEM_BYTES);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr, input logic [1:0] mode);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < nbytes(mode); i++) v = v | (DW'(ref_mem[int'(addr) + i]) << (8 * i));
        return v;
    endfunction

    task automatic ref_write(input logic [AW-1:0] addr, input logic [1:0] mode, input logic [DW-1:0] d);
        for (int i = 0; i < nbytes(mode); i++) ref_mem[int'(addr) + i] = d[8*i +: 8];
    endtask

    task automatic apply_inputs();
        txn_t z = '{default: '0};
        txn_t a = (q0.size() > 0) ? q0[0] : z;
        txn_t b = (q1.size() > 0) ? q1[0] : z;
        bus.req0   = (q0.size() > 0);
        bus.we0    = a.we;
        bus.mode0  = a.mode;
        bus.addr0  = a.addr;
        bus.wdata0 = a.wdata;
        bus.req1   = (q1.size() > 0);
        bus.we1    = b.we;
        bus.mode1  = b.mode;
        bus.addr1  = b.addr;
        bus.wdata1 = b.wdata;
        bus.lock1  = b.lock;
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt0",    bus.gnt0,        0);
        check("rst_gnt1",    bus.gnt1,        0);
        check("rst_rvalid0", bus.rvalid0,     0);
        check("rst_rvalid1", bus.rvalid1,     0);
        check("rst_err0",    bus.err0,        0);
        check("rst_err1",    bus.err1,        0);
        check("rst_rdata0",  bus.rdata0,      0);
        check("rst_rdata1",  bus.rdata1,      0);
        check("rst_wr_en",   bus.mem_wr_en,   0);
        check("rst_addr",    bus.mem_addr,    0);
        check("rst_wdata",   bus.mem_w_data,  0);
        check("rst_mode",    bus.mem_rw_mode, 0);
    endtask

    // Asserts reset mid-cycle; outputs must clear at once and no response
    // may appear while reset is held.
    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q0.delete();
        q1.delete();
        hist.delete();
        m_last      = 1;
        m_run       = 0;
        m_addr_hold = '0;
        m_mode_hold = '0;
        exp_rv      = '{0, 0};
        n_rv        = '{0, 0};
        apply_inputs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_rvalid0", bus.rvalid0, 0);
            check("rst_hold_rvalid1", bus.rvalid1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: check the previous cycle's responses and this cycle's
    // grant and memory drive, then advance the model.
    task automatic step();
        txn_t t = '{default: '0};
        int   w;
        bit   owned, bad, r0, r1;
        apply_inputs();
        @(negedge clk);
        check("rvalid0", bus.rvalid0, exp_rv[0]);
        check("rvalid1", bus.rvalid1, exp_rv[1]);
        if (exp_rv[0]) begin
            check("rdata0", bus.rdata0, exp_rd[0]);
            check("err0",   bus.err0,   exp_err[0]);
        end
        if (exp_rv[1]) begin
            check("rdata1", bus.rdata1, exp_rd[1]);
            check("err1",   bus.err1,   exp_err[1]);
        end
        if (bus.rvalid0) begin n_rv[0]++; last_rd[0] = bus.rdata0; last_err[0] = bus.err0; end
        if (bus.rvalid1) begin n_rv[1]++; last_rd[1] = bus.rdata1; last_err[1] = bus.err1; end

        r0    = (q0.size() > 0);
        r1    = (q1.size() > 0);
        owned = (m_run > 0) && (m_run < LM) && r1 && q1[0].lock;
        if (owned)         w = 1;
        else if (r0 && r1) w = (m_last == 1) ? 0 : 1;
        else if (r0)       w = 0;
        else if (r1)       w = 1;
        else               w = -1;
        check("gnt0", bus.gnt0, w == 0);
        check("gnt1", bus.gnt1, w == 1);

        if (w >= 0) begin
            t   = (w == 0) ? q0[0] : q1[0];
            bad = is_bad(t.mode, t.addr);
            check("mem_addr", bus.mem_addr,    t.addr);
            check("mem_mode", bus.mem_rw_mode, t.mode);
            check("mem_wr_en", bus.mem_wr_en,  t.we && !bad);
            if (t.we && !bad) check("mem_w_data", bus.mem_w_data, t.wdata);
            m_addr_hold = t.addr;
            m_mode_hold = t.mode;
        end else begin
            bad = 1'b0;
            check("mem_wr_en_idle", bus.mem_wr_en,   0);
            check("mem_addr_hold",  bus.mem_addr,    m_addr_hold);
            check("mem_mode_hold",  bus.mem_rw_mode, m_mode_hold);
        end

        exp_rv = '{0, 0};
        if (w >= 0) begin
            exp_rv[w]  = 1'b1;
            exp_err[w] = bad;
            exp_rd[w]  = (!t.we && !bad) ? ref_read(t.addr, t.mode) : '0;
            if (t.we && !bad) ref_write(t.addr, t.mode, t.wdata);
            m_last = w;
        end
        if (w == 1 && t.lock) m_run = owned ? m_run + 1 : 1;
        else                  m_run = 0;
        hist.push_back(w);

        @(posedge clk);
        #1;
        if (w == 0) void'(q0.pop_front());
        if (w == 1) void'(q1.pop_front());
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size()) > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_left", q0.size() + q1.size(), 0);
        step();
    endtask

    function automatic txn_t mk(input logic we, input logic [1:0] mode, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic lock);
        txn_t t;
        t.we = we; t.mode = mode; t.addr = addr; t.wdata = wdata; t.lock = lock;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int port);
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.mode  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        t.addr  = ($urandom_range(0, 7) == 0) ? AW'(MEM_BYTES - 8 + $urandom_range(0, 7))
                                              : AW'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0 && t.mode != 2'd3)
            t.addr = t.addr & ~AW'(nbytes(t.mode) - 1);
        t.wdata = $urandom;
        t.lock  = (port == 1) && ($urandom_range(0, 99) < 30);
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        mem_clr = 1'b1;
        reset_dut();
        mem_clr = 1'b0;

        // Single read of preloaded word
        pre_addr = '0;
        pre_word = 32'h0906_0301;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        ref_write(12'h000, 2'd2, 32'h0906_0301);
        hist.delete();
        n_rv = '{0, 0};
        q0.push_back(mk(1'b0, 2'd2, 12'h000, '0, 1'b0));
        drain();
        check("single_gnt0",  hist[0],    0);
        check("single_rv",    n_rv[0],    1);
        check("single_rdata", last_rd[0], 32'h0906_0301);
        check("single_err",   last_err[0], 0);

        // Byte write on port 1, word read back on port 0
        q1.push_back(mk(1'b1, 2'd0, 12'h010, 32'h1234_56AB, 1'b0));
        drain();
        check("bw_err", last_err[1], 0);
        check("bw_rdata", last_rd[1], 0);
        q0.push_back(mk(1'b0, 2'd2, 12'h010, '0, 1'b0));
        drain();
        check("br_rdata", last_rd[0], 32'h0000_00AB);

        // Error cases and unchanged memory
        q0.push_back(mk(1'b1, 2'd1, 12'h005, 32'h0000_BEEF, 1'b0));
        drain();
        check("err_hw_err",   last_err[0], 1);
        check("err_hw_rdata", last_rd[0],  0);
        q0.push_back(mk(1'b0, 2'd2, 12'hFFE, '0, 1'b0));
        drain();
        check("err_top_err",   last_err[0], 1);
        check("err_top_rdata", last_rd[0],  0);
        q0.push_back(mk(1'b0, 2'd2, 12'h004, '0, 1'b0));
        drain();
        check("err_unchanged", last_rd[0], 0);
        check("err_ok_err",    last_err[0], 0);

        // Reset while a read response is pending
        q0.push_back(mk(1'b0, 2'd2, 12'h000, '0, 1'b0));
        apply_inputs();
        @(negedge clk);
        check("rstmid_gnt0", bus.gnt0, 1);
        reset_dut();

        // Tie from reset: grants alternate starting with port 0
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 2'd2, AW'(4 * i), '0, 1'b0));
            q1.push_back(mk(1'b0, 2'd0, AW'(32 + i), '0, 1'b0));
        end
        drain();
        for (int i = 0; i < 8; i++) check("tie_order", hist[i], i % 2);
        check("tie_rv0", n_rv[0], 4);
        check("tie_rv1", n_rv[1], 4);

        // Lock run bounded by LOCK_MAX
        reset_dut();
        q0.push_back(mk(1'b0, 2'd2, 12'h000, '0, 1'b0));
        q0.push_back(mk(1'b0, 2'd2, 12'h004, '0, 1'b0));
        for (int i = 0; i < 20; i++)
            q1.push_back(mk(1'b1, 2'd2, AW'(64 + 4 * i), $urandom, 1'b1));
        drain();
        run = 0;
        for (int i = 1; i < hist.size() && hist[i] == 1; i++) run++;
        check("lock_first", hist[0], 0);
        check("lock_run",   run,     LM);
        check("lock_gnt0",  hist[LM + 1], 0);
        check("lock_resume", hist[LM + 2], 1);

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 99) < 60) q0.push_back(rand_txn(0));
            if (q1.size() == 0 && $urandom_range(0, 99) < 60) q1.push_back(rand_txn(1));
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
